// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified I/D RAM port arbiter: FSM state encoding,
// grant identifiers and wait-state limits.
package mem_arb_pkg;

    // Largest supported number of extra RAM cycles per access.
    localparam int WAIT_STATES_MAX = 15;

    // Width of the wait-state down-counter.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACC_IF   = 3'd1,
        ACC_MEM  = 3'd2,
        RESP_IF  = 3'd3,
        RESP_MEM = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    // Convert the integer wait-state parameter into a counter load value,
    // saturating anything above the supported maximum.
    function automatic logic [CNT_W-1:0] wait_load_value(input int ws);
        if (ws > WAIT_STATES_MAX) begin
            return CNT_W'(WAIT_STATES_MAX);
        end else if (ws < 0) begin
            return '0;
        end else begin
            return CNT_W'(ws);
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-side signals of the arbiter.
// Handshake: a requester raises its req (with address/data stable) and holds
// it until the matching ready pulses for one cycle; it drops or changes the
// request in the cycle after ready. The RAM side is a plain select/write
// enable port whose read data is valid on the last cycle of an access.
interface mem_port_arbiter_if #(
    parameter int RAM_AW = 10
);
    // Fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              if_stall;

    // Load/store port
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_stall;

    // RAM port
    logic              ram_cs;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr,
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        input  ram_rdata,
        output if_rdata, if_ready, if_stall,
        output mem_rdata, mem_ready, mem_stall,
        output ram_cs, ram_we, ram_addr, ram_wdata
    );

    // Requester / RAM side
    modport master (
        output if_req, if_addr,
        output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        output ram_rdata,
        input  if_rdata, if_ready, if_stall,
        input  mem_rdata, mem_ready, mem_stall,
        input  ram_cs, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that times the RAM wait states of one access.
// Load has priority over decrement; the counter never wraps below zero.
module wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Counter register: load a new wait count or step down toward zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-port unified instruction/data RAM shared
// by the fetch and memory stages. One access at a time: IDLE picks a
// requester, ACC_* drives the RAM for WAIT_STATES+1 cycles, RESP_* pulses
// the matching ready for one cycle with data from a response register.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break simultaneous requests
// in favour of the requester not granted last; otherwise the memory stage
// always wins a tie (it holds the older instruction).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int RAM_AW      = 10
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output arb_state_t          fsm_state
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load_value(WAIT_STATES);

    arb_state_t        state_q;
    arb_state_t        state_d;

    logic              mem_req;
    logic              any_req;
    logic              grant_mem;
    logic              start_acc;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    logic [RAM_AW-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_we;

    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    logic              in_acc;

    // A simultaneous read+write request is treated as a store.
    assign mem_req   = bus.mem_rd_req | bus.mem_wr_req;
    assign any_req   = mem_req | bus.if_req;
    assign start_acc = (state_q == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_t last_grant;

    // Grant decision: on a tie, favour whichever side was not served last.
    always_comb begin
        grant_mem = mem_req;
        if (mem_req && bus.if_req) begin
            grant_mem = (last_grant == GRANT_IF);
        end
    end

    // Remember the most recent winner; resets to IF so the first tie goes to MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_IF;
        end else if (start_acc) begin
            last_grant <= grant_mem ? GRANT_MEM : GRANT_IF;
        end
    end
`else
    // Fixed priority: the memory stage always beats fetch.
    assign grant_mem = mem_req;
`endif

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and wait-counter control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    cnt_load = 1'b1;
                    state_d  = grant_mem ? ACC_MEM : ACC_IF;
                end
            end
            ACC_IF: begin
                if (cnt_zero) begin
                    state_d = RESP_IF;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACC_MEM: begin
                if (cnt_zero) begin
                    state_d = RESP_MEM;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP_IF:  state_d = IDLE;
            RESP_MEM: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Latch the granted request so the RAM sees stable values for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else if (start_acc) begin
            if (grant_mem) begin
                lat_addr  <= bus.mem_addr[RAM_AW+1:2];
                lat_wdata <= bus.mem_wdata;
                lat_we    <= bus.mem_wr_req;
            end else begin
                lat_addr  <= bus.if_addr[RAM_AW+1:2];
                lat_wdata <= '0;
                lat_we    <= 1'b0;
            end
        end
    end

    // Capture read data on the last access cycle; a store leaves mem_rdata untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if ((state_q == ACC_IF) && cnt_zero) begin
                if_rdata_q <= bus.ram_rdata;
            end
            if ((state_q == ACC_MEM) && cnt_zero && !lat_we) begin
                mem_rdata_q <= bus.ram_rdata;
            end
        end
    end

    // Output decode from the registered state and latched request.
    always_comb begin
        in_acc        = (state_q == ACC_IF) || (state_q == ACC_MEM);
        bus.ram_cs    = in_acc;
        bus.ram_we    = in_acc & lat_we;
        bus.ram_addr  = in_acc ? lat_addr  : '0;
        bus.ram_wdata = in_acc ? lat_wdata : '0;
        bus.if_ready  = (state_q == RESP_IF);
        bus.mem_ready = (state_q == RESP_MEM);
        bus.if_rdata  = if_rdata_q;
        bus.mem_rdata = mem_rdata_q;
        bus.if_stall  = bus.if_req & ~bus.if_ready;
        bus.mem_stall = mem_req & ~bus.mem_ready;
        fsm_state     = state_q;
    end

    // Byte-offset and above-RAM address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:RAM_AW+2], bus.if_addr[1:0],
                                bus.mem_addr[31:RAM_AW+2], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with WAIT_STATES=1 for
// fetch, load/store, tie-break and async reset; a second with WAIT_STATES=0
// for back-to-back fetch timing.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.RAM_AW(10)) bus ();
    mem_port_arbiter_if #(.RAM_AW(10)) bus0 ();
    arb_state_t fsm_state;
    arb_state_t fsm_state0;

    mem_port_arbiter #(.WAIT_STATES(1), .RAM_AW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    mem_port_arbiter #(.WAIT_STATES(0), .RAM_AW(10)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0.slave),
        .fsm_state (fsm_state0)
    );

    // ---------------- RAM models ----------------
    logic [31:0] ram     [0:1023];
    logic [31:0] ram0    [0:1023];
    logic [31:0] ref_mem [0:1023];

    assign bus.ram_rdata  = ram[bus.ram_addr];
    assign bus0.ram_rdata = ram0[bus0.ram_addr];

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    end

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];
    logic [31:0] if0_exp_q[$];
    logic [31:0] mem_rdata_model = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Ready monitor: every ready pops an expected data word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.if_ready || bus.mem_ready) begin
                chk("ready_onehot", {31'b0, bus.if_ready & bus.mem_ready}, 32'd0);
                chk("cs_during_resp", {31'b0, bus.ram_cs}, 32'd0);
            end
            if (bus.if_ready) begin
                if (if_exp_q.size() == 0) chk("if_unexpected_ready", 32'd1, 32'd0);
                else chk("if_rdata", bus.if_rdata, if_exp_q.pop_front());
            end
            if (bus.mem_ready) begin
                if (mem_exp_q.size() == 0) chk("mem_unexpected_ready", 32'd1, 32'd0);
                else chk("mem_rdata", bus.mem_rdata, mem_exp_q.pop_front());
            end
            if (bus0.if_ready) begin
                if (if0_exp_q.size() == 0) chk("ws0_unexpected_ready", 32'd1, 32'd0);
                else chk("ws0_if_rdata", bus0.if_rdata, if0_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one access on the WAIT_STATES=1 instance and observe it cycle by cycle.
    // Cycle 0 is the cycle in which the request is first presented.
    task automatic access(input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int rdy_at, output int cs_n,
                          output int we_n, output logic [7:0] stall_mask, output bit addr_ok);
        logic [9:0] w;
        w = addr[11:2];
        rdy_at = -1; cs_n = 0; we_n = 0; stall_mask = '0; addr_ok = 1'b1;
        if (!is_mem) begin
            if_exp_q.push_back(ref_mem[w]);
        end else if (we) begin
            mem_exp_q.push_back(mem_rdata_model);
            ref_mem[w] = wdata;
        end else begin
            mem_exp_q.push_back(ref_mem[w]);
            mem_rdata_model = ref_mem[w];
        end
        @(negedge clk);
        if (is_mem) begin
            bus.mem_rd_req = ~we; bus.mem_wr_req = we;
            bus.mem_addr = addr;  bus.mem_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int k = 0; k < 20 && rdy_at < 0; k++) begin
            #1;
            if (bus.ram_cs) begin
                cs_n++;
                if (bus.ram_we) we_n++;
                if (bus.ram_addr !== w) addr_ok = 1'b0;
            end
            if (k < 8) stall_mask[k] = is_mem ? bus.mem_stall : bus.if_stall;
            if (is_mem ? bus.mem_ready : bus.if_ready) rdy_at = k;
            @(negedge clk);
        end
        bus.if_req = 1'b0; bus.mem_rd_req = 1'b0; bus.mem_wr_req = 1'b0;
        if (rdy_at < 0) chk("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        mem_rdata_model = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rdy, csn, wen, mem_at, if_at, cs0;
        logic [7:0] sm;
        bit aok;
        int order[$];
        int rd0[$];

        rst = 1'b0;
        bus.if_req = 0;  bus.if_addr = '0;  bus.mem_rd_req = 0; bus.mem_wr_req = 0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        bus0.if_req = 0; bus0.if_addr = '0; bus0.mem_rd_req = 0; bus0.mem_wr_req = 0;
        bus0.mem_addr = '0; bus0.mem_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
        end
        ref_mem[4]  = 32'hE3A0_1005;
        ref_mem[16] = 32'h1234_5678;
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = ref_mem[i];
            ram0[i] = ref_mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_if_ready",  {31'b0, bus.if_ready},  32'd0);
        chk("rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("rst_ram_cs",    {31'b0, bus.ram_cs},    32'd0);
        chk("rst_ram_we",    {31'b0, bus.ram_we},    32'd0);
        chk("rst_ram_addr",  {22'b0, bus.ram_addr},  32'd0);
        chk("rst_if_rdata",  bus.if_rdata,  32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_stalls",    {30'b0, bus.if_stall, bus.mem_stall}, 32'd0);
        chk("rst_state",     32'(fsm_state), 32'(IDLE));
        @(negedge clk); rst = 1'b1;

        // Fetch read of 0x10
        access(1'b0, 1'b0, 32'h10, 32'h0, rdy, csn, wen, sm, aok);
        chk("fetch_latency",   rdy, 32'd3);
        chk("fetch_cs_cycles", csn, 32'd2);
        chk("fetch_we_cycles", wen, 32'd0);
        chk("fetch_ram_addr",  {31'b0, aok}, 32'd1);
        chk("fetch_stall",     {24'b0, sm}, 32'h07);

        // Load 0x40 to give mem_rdata a known non-zero value
        access(1'b1, 1'b0, 32'h40, 32'h0, rdy, csn, wen, sm, aok);
        chk("load1_latency", rdy, 32'd3);
        chk("load1_we_cycles", wen, 32'd0);

        // Store 0xDEADBEEF to 0x20; mem_rdata must hold the previous load value
        access(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, rdy, csn, wen, sm, aok);
        chk("store_latency",   rdy, 32'd3);
        chk("store_cs_cycles", csn, 32'd2);
        chk("store_we_cycles", wen, 32'd2);
        chk("store_ram_addr",  {31'b0, aok}, 32'd1);
        chk("store_stall",     {24'b0, sm}, 32'h07);
        chk("store_ram_word",  ram[8], 32'hDEAD_BEEF);

        // Load back 0x20
        access(1'b1, 1'b0, 32'h20, 32'h0, rdy, csn, wen, sm, aok);
        chk("load2_latency",  rdy, 32'd3);
        chk("load2_ram_addr", {31'b0, aok}, 32'd1);

        // Tie A: MEM first, IF WAIT_STATES+3 cycles later
        pulse_reset();
        if_exp_q.push_back(ref_mem[4]);
        mem_exp_q.push_back(ref_mem[16]);
        mem_rdata_model = ref_mem[16];
        mem_at = -1; if_at = -1;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.mem_rd_req = 1'b1; bus.mem_addr = 32'h40;
        for (int k = 0; k < 30 && if_at < 0; k++) begin
            #1;
            if (bus.mem_ready) mem_at = k;
            if (bus.if_ready)  if_at  = k;
            @(negedge clk);
            if (mem_at == k) bus.mem_rd_req = 1'b0;
        end
        bus.if_req = 1'b0; bus.mem_rd_req = 1'b0;
        chk("tie_mem_ready_cycle", mem_at, 32'd3);
        chk("tie_if_ready_cycle",  if_at,  32'd7);

        // Tie B: both held through three grants
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mem_exp_q.push_back(ref_mem[16]);
        if_exp_q.push_back(ref_mem[4]);
        mem_exp_q.push_back(ref_mem[16]);
`else
        repeat (3) mem_exp_q.push_back(ref_mem[16]);
`endif
        @(negedge clk);
        bus.if_req = 1'b1; bus.mem_rd_req = 1'b1;
        for (int k = 0; k < 40 && order.size() < 3; k++) begin
            #1;
            if (bus.mem_ready) order.push_back(1);
            if (bus.if_ready)  order.push_back(0);
            @(negedge clk);
        end
        bus.if_req = 1'b0; bus.mem_rd_req = 1'b0;
        chk("tieb_grant_count", order.size(), 32'd3);
        if (order.size() == 3) begin
            chk("tieb_grant0", order[0], 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("tieb_grant1", order[1], 32'd0);
`else
            chk("tieb_grant1", order[1], 32'd1);
`endif
            chk("tieb_grant2", order[2], 32'd1);
        end

        // Async reset in the middle of ACC_MEM
        @(negedge clk);
        bus.mem_rd_req = 1'b1; bus.mem_addr = 32'h40;
        @(negedge clk);
        chk("pre_rst_state", 32'(fsm_state), 32'(ACC_MEM));
        chk("pre_rst_cs", {31'b0, bus.ram_cs}, 32'd1);
        #2;
        rst = 1'b0; bus.mem_rd_req = 1'b0;
        #1;
        chk("arst_ram_cs",    {31'b0, bus.ram_cs},    32'd0);
        chk("arst_ram_addr",  {22'b0, bus.ram_addr},  32'd0);
        chk("arst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
        chk("arst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("arst_if_rdata",  bus.if_rdata,  32'd0);
        chk("arst_mem_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("arst_state",     32'(fsm_state), 32'(IDLE));
        mem_rdata_model = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        access(1'b0, 1'b0, 32'h10, 32'h0, rdy, csn, wen, sm, aok);
        chk("post_rst_fetch_latency", rdy, 32'd3);

        // WAIT_STATES=0: back-to-back fetches of words 1,2,3
        if0_exp_q.push_back(ref_mem[1]);
        if0_exp_q.push_back(ref_mem[2]);
        if0_exp_q.push_back(ref_mem[3]);
        cs0 = 0;
        @(negedge clk);
        bus0.if_req = 1'b1; bus0.if_addr = 32'h4;
        for (int k = 0; k < 30 && rd0.size() < 3; k++) begin
            #1;
            if (bus0.ram_cs) begin
                cs0++;
                chk("ws0_ram_addr", {22'b0, bus0.ram_addr}, rd0.size() + 1);
            end
            if (bus0.if_ready) rd0.push_back(k);
            @(negedge clk);
            if (rd0.size() > 0 && rd0[$] == k) bus0.if_addr = 32'h4 * (rd0.size() + 1);
        end
        bus0.if_req = 1'b0;
        chk("ws0_ready_count", rd0.size(), 32'd3);
        chk("ws0_cs_cycles", cs0, 32'd3);
        if (rd0.size() == 3) begin
            chk("ws0_ready0", rd0[0], 32'd2);
            chk("ws0_ready1", rd0[1], 32'd5);
            chk("ws0_ready2", rd0[2], 32'd8);
        end

        // Every expected response consumed
        repeat (3) @(negedge clk);
        chk("if_queue_empty",  if_exp_q.size(),  32'd0);
        chk("mem_queue_empty", mem_exp_q.size(), 32'd0);
        chk("ws0_queue_empty", if0_exp_q.size(), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
